mtr_drv: RTL and testbench
==========================

Name: mtr_drv

Overview:
- Downstream consumer of the balance controller's lft_spd/rght_spd.
- Converts each signed 12-bit motor speed into a saturated 11-bit duty.
- Generates glitch-free, period-synchronous PWM from a shared 2048-cycle counter.
- Drives complementary high/low-side gate signals per motor with enforced non-overlap (dead time) for the H-bridges.

Parameters:
DEAD, 32, dead-time in clk cycles both gate outputs are held low after any PWM edge (legal 1..63)

Ports:
clk  input  1  system clock (50 MHz)
rst  input  1  asynchronous active-high reset
en  input  1  drive enable; low forces all gate outputs low
lft_spd  input  12  signed left motor speed from balance controller
rght_spd  input  12  signed right motor speed from balance controller
lft_pwm1  output  1  left bridge high-side gate
lft_pwm2  output  1  left bridge low-side gate
rght_pwm1  output  1  right bridge high-side gate
rght_pwm2  output  1  right bridge low-side gate
pwm_sync  output  1  one-cycle pulse on the clock where the period counter is 2047

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high. All state is reset by rst; no synchronous clear.
- Reset values:
  - all four gate outputs 0; pwm_sync 0
  - period counter cnt 0
  - input registers 0
  - shadow duties 11'h400 (zero speed)
  - PWM_sig registers 0; dead-time counters 0
- Input stage: lft_spd/rght_spd registered every clk (1 cycle).
- Duty math, per motor, on the registered speed s:
  - clamp s to -1024..+1023 (s < -1024 gives -1024; s > 1023 gives 1023)
  - duty_next = clamp + 1024, 11 bits unsigned, range 0..2047
  - speed 0 gives 1024 (50%); 12'h800 (-2048) gives 0; 12'h7FF gives 2047.
- Period counter:
  - cnt is 11-bit, free-running, +1 every clk, wraps 2047 to 0; runs regardless of en.
  - pwm_sync = (cnt == 2047), combinational from the cnt register.
- Shadow load: on the clock edge where cnt == 2047, shadow duty <= duty_next. The shadow never changes mid-period.
- PWM_sig, registered: PWM_sig <= (cnt < shadow_duty).
  - High for exactly shadow_duty cycles per 2048-cycle period.
  - duty 0 gives always low; duty 2047 gives low 1 cycle per period.
- Dead-time, per motor, with prev = PWM_sig delayed 1 clk:
  - dt_cnt is 6-bit.
  - If PWM_sig != prev or en == 0: dt_cnt <= 0.
  - Otherwise dt_cnt increments, saturating at DEAD.
  - pwm1 <= en & PWM_sig & (dt_cnt == DEAD) & (PWM_sig == prev)
  - pwm2 <= en & ~PWM_sig & (dt_cnt == DEAD) & (PWM_sig == prev)
- Invariants:
  - pwm1 and pwm2 of the same motor are never high together.
  - After every PWM_sig edge, both are low for at least DEAD+1 cycles.
  - A PWM_sig pulse or gap of DEAD cycles or fewer never asserts the corresponding output.
- en:
  - Deassert: all gate outputs 0 on the next clk edge.
  - Re-assert: dead-time restarts, so outputs are low for at least DEAD+1 cycles.
  - cnt and shadow registers are unaffected by en.
- Speed change latency: new value seen at the next cnt == 2047 edge, at least 2 clk after input. Several input changes within one period: only the value registered at that edge is used.
- Reset mid-period: outputs drop to 0 asynchronously; restart from cnt 0 with 50% duty.

Test Plan:
- Reset then en=1, lft_spd=0 -> lft_pwm1 high (1024-DEAD-1) cycles and lft_pwm2 high (1024-DEAD-1) cycles per period, never both; pwm_sync every 2048 cycles.
- lft_spd=12'h200 (+512) -> shadow 1536 after next pwm_sync; PWM_sig high 1536/2048; lft_pwm1 high 1536-33 cycles per period.
- rght_spd=12'h7FF then 12'h800 -> duty 2047 then 0. Both saturating.
  - 0: rght_pwm1 never high and rght_pwm2 continuously high after dead-time.
  - 2047: the 1-cycle low gap never asserts rght_pwm2.
- Change lft_spd mid-period (cnt=500, from 0 to -512) -> duty stays 1024 until cnt==2047 edge, then 512; no runt pulse in the current period.
- en dropped at cnt=300 with pwm1 high -> all outputs 0 next cycle; en re-raised -> outputs stay 0 at least 33 cycles, then resume.
- Assert rst mid-period with pwm2 high -> outputs 0 immediately (no clk); after release cnt=0, shadow=1024, first gate high no earlier than cycle 34.

Source files
------------

// File: rtl/mtr_drv.sv
// mtr_drv: dual-motor H-bridge PWM driver.
// Each signed 12-bit speed is clamped to a 0..2047 duty, latched into a
// shadow register once per 2048-cycle period, compared against a shared
// free-running counter, and then split into complementary high/low-side
// gate signals. Both gates stay low for a dead-time window after every PWM
// edge and after drive enable is re-asserted.
module mtr_drv #(
  parameter int DEAD = 32                 // dead time in clk cycles (1..63)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [11:0] lft_spd,
  input  logic [11:0] rght_spd,
  output logic        lft_pwm1,
  output logic        lft_pwm2,
  output logic        rght_pwm1,
  output logic        rght_pwm2,
  output logic        pwm_sync
);

  localparam logic [5:0]        DEAD_C   = 6'(DEAD);
  localparam logic [10:0]       CNT_LAST = 11'h7FF;
  localparam logic [10:0]       DUTY_MID = 11'h400;
  localparam logic signed [11:0] SPD_MIN = -12'sd1024;
  localparam logic signed [11:0] SPD_MAX = 12'sd1023;
  localparam logic signed [11:0] SPD_OFS = 12'sd1024;

  // Clamp a signed speed to -1024..1023 and offset it into an unsigned duty.
  function automatic logic [10:0] sat_duty(input logic signed [11:0] s);
    logic signed [11:0] sum;
    if (s < SPD_MIN) begin
      sat_duty = 11'd0;
    end else if (s > SPD_MAX) begin
      sat_duty = 11'd2047;
    end else begin
      sum      = s + SPD_OFS;
      sat_duty = sum[10:0];
    end
  endfunction

  // Index 0 is the left motor, index 1 the right motor.
  logic [1:0][11:0] spd_q;
  logic [10:0]      cnt_q, cnt_d;
  logic [1:0][10:0] duty_q, duty_d;
  logic [1:0]       sig_q, sig_d;
  logic [1:0]       prev_q;
  logic [1:0][5:0]  dt_q, dt_d;
  logic [1:0]       pwm1_q, pwm1_d;
  logic [1:0]       pwm2_q, pwm2_d;

  // Next-state logic: counter, shadow load, PWM compare and dead-time gating.
  always_comb begin
    logic stable;
    cnt_d  = cnt_q + 11'd1;
    duty_d = duty_q;
    sig_d  = '0;
    dt_d   = dt_q;
    pwm1_d = '0;
    pwm2_d = '0;
    stable = 1'b0;
    for (int m = 0; m < 2; m++) begin
      // Shadow only follows the speed at the period boundary, so a period
      // already in progress keeps its duty and never emits a runt pulse.
      if (cnt_q == CNT_LAST) begin
        duty_d[m] = sat_duty(spd_q[m]);
      end
      sig_d[m] = (cnt_q < duty_q[m]);
      stable   = (sig_q[m] == prev_q[m]);
      // Any PWM edge or a disabled drive restarts the dead-time window.
      if (!stable || !en) begin
        dt_d[m] = 6'd0;
      end else if (dt_q[m] != DEAD_C) begin
        dt_d[m] = dt_q[m] + 6'd1;
      end
      pwm1_d[m] = en &  sig_q[m] & (dt_q[m] == DEAD_C) & stable;
      pwm2_d[m] = en & ~sig_q[m] & (dt_q[m] == DEAD_C) & stable;
    end
  end

  // State registers; reset also drops the gates asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spd_q  <= '0;
      cnt_q  <= '0;
      duty_q <= {DUTY_MID, DUTY_MID};
      sig_q  <= '0;
      prev_q <= '0;
      dt_q   <= '0;
      pwm1_q <= '0;
      pwm2_q <= '0;
    end else begin
      spd_q  <= {rght_spd, lft_spd};
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      sig_q  <= sig_d;
      prev_q <= sig_q;
      dt_q   <= dt_d;
      pwm1_q <= pwm1_d;
      pwm2_q <= pwm2_d;
    end
  end

  assign lft_pwm1  = pwm1_q[0];
  assign lft_pwm2  = pwm2_q[0];
  assign rght_pwm1 = pwm1_q[1];
  assign rght_pwm2 = pwm2_q[1];
  assign pwm_sync  = (cnt_q == CNT_LAST);

endmodule

// File: tb/tb_mtr_drv.sv
// Testbench for mtr_drv: table of steady-state speed vectors with
// hand-computed per-period gate high counts, plus directed sequences for
// mid-period speed change, enable drop/re-raise and mid-period reset.
module tb_mtr_drv;
  localparam int DEAD = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [11:0] lft_spd, rght_spd;
  logic        lft_pwm1, lft_pwm2, rght_pwm1, rght_pwm2, pwm_sync;

  always #5 clk = ~clk;

  mtr_drv #(.DEAD(DEAD)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .lft_spd   (lft_spd),
    .rght_spd  (rght_spd),
    .lft_pwm1  (lft_pwm1),
    .lft_pwm2  (lft_pwm2),
    .rght_pwm1 (rght_pwm1),
    .rght_pwm2 (rght_pwm2),
    .pwm_sync  (pwm_sync)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [11:0] l;
    logic [11:0] r;
    int          l1, l2, r1, r2;   // gate high cycles per 2048-cycle period
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_sync(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2100; i++) begin
      tick();
      if (pwm_sync) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk({name, "_sync_timeout"}, 0, 1);
  endtask

  task automatic measure(output int l1, output int l2, output int r1,
                         output int r2, output int ov, output int sy);
    l1 = 0; l2 = 0; r1 = 0; r2 = 0; ov = 0; sy = 0;
    for (int i = 0; i < 2048; i++) begin
      tick();
      l1 += int'(lft_pwm1);
      l2 += int'(lft_pwm2);
      r1 += int'(rght_pwm1);
      r2 += int'(rght_pwm2);
      ov += int'((lft_pwm1 & lft_pwm2) | (rght_pwm1 & rght_pwm2));
      sy += int'(pwm_sync);
    end
  endtask

  function automatic int out_sum();
    return int'(lft_pwm1) + int'(lft_pwm2) + int'(rght_pwm1) + int'(rght_pwm2)
         + int'(pwm_sync);
  endfunction

  // Entered with rst high; releases it and checks the restart timing.
  task automatic reset_release(input string tag);
    int first_l, first_r, sync_at;
    chk({tag, "_outs_in_reset"}, out_sum(), 0);
    rst = 1'b0;
    first_l = -1; first_r = -1; sync_at = -1;
    for (int n = 1; n <= 2100; n++) begin
      tick();
      if (first_l < 0 && (lft_pwm1 || lft_pwm2))   first_l = n;
      if (first_r < 0 && (rght_pwm1 || rght_pwm2)) first_r = n;
      if (pwm_sync) begin
        sync_at = n;
        break;
      end
    end
    chk({tag, "_first_lft_gate"}, first_l, 35);
    chk({tag, "_first_rght_gate"}, first_r, 35);
    chk({tag, "_first_sync"}, sync_at, 2047);
  endtask

  initial begin
    int l1, l2, r1, r2, ov, sy, first;

    tbl[0] = '{12'h000, 12'h000,  991,  991,  991,  991};
    tbl[1] = '{12'h200, 12'h7FF, 1503,  479, 2014,    0};
    tbl[2] = '{12'hE00, 12'h800,  479, 1503,    0, 2048};
    tbl[3] = '{12'h064, 12'h3FF, 1091,  891, 2014,    0};
    tbl[4] = '{12'hFFF, 12'hC00,  990,  992,    0, 2048};
    tbl[5] = '{12'hA00, 12'h5FF,    0, 2048, 2014,    0};

    rst = 1'b1; en = 1'b1; lft_spd = '0; rght_spd = '0;
    repeat (3) tick();
    reset_release("por");

    // Steady-state duty vectors.
    for (int v = 0; v < 6; v++) begin
      lft_spd  = tbl[v].l;
      rght_spd = tbl[v].r;
      repeat (2) tick();
      wait_sync($sformatf("v%0d", v));
      repeat (200) tick();
      measure(l1, l2, r1, r2, ov, sy);
      chk($sformatf("v%0d_lft_pwm1", v), l1, tbl[v].l1);
      chk($sformatf("v%0d_lft_pwm2", v), l2, tbl[v].l2);
      chk($sformatf("v%0d_rght_pwm1", v), r1, tbl[v].r1);
      chk($sformatf("v%0d_rght_pwm2", v), r2, tbl[v].r2);
      chk($sformatf("v%0d_overlap", v), ov, 0);
      chk($sformatf("v%0d_sync_count", v), sy, 1);
    end

    // Speed change at cnt=500 must not affect the current period.
    lft_spd  = 12'h000;
    rght_spd = 12'h800;
    repeat (2) tick();
    wait_sync("mid_a");
    wait_sync("mid_b");
    l1 = 0; l2 = 0;
    for (int i = 1; i <= 2048; i++) begin
      tick();
      if (i == 501) lft_spd = 12'hE00;
      l1 += int'(lft_pwm1);
      l2 += int'(lft_pwm2);
    end
    chk("mid_cur_lft_pwm1", l1, 991);
    chk("mid_cur_lft_pwm2", l2, 991);
    measure(l1, l2, r1, r2, ov, sy);
    chk("mid_next_lft_pwm1", l1, 479);
    chk("mid_next_lft_pwm2", l2, 1503);

    // Enable dropped while the high side conducts, then re-raised.
    repeat (301) tick();
    chk("en_pwm1_before_drop", int'(lft_pwm1), 1);
    en = 1'b0;
    tick();
    chk("en_drop_outs", int'(lft_pwm1) + int'(lft_pwm2) + int'(rght_pwm1)
                        + int'(rght_pwm2), 0);
    repeat (10) tick();
    en = 1'b1;
    first = -1;
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (lft_pwm1 || lft_pwm2) begin
        first = n;
        break;
      end
    end
    chk("en_resume_cycles", first, 33);
    chk("en_resume_is_pwm1", int'(lft_pwm1), 1);
    chk("en_resume_pwm2_low", int'(lft_pwm2), 0);

    // Reset asserted mid-period while the low side conducts.
    wait_sync("rst");
    repeat (1001) tick();
    chk("rst_pwm2_before", int'(lft_pwm2), 1);
    #2 rst = 1'b1;
    #1 chk("rst_async_outs", out_sum(), 0);
    repeat (3) tick();
    reset_release("mid");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
